alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised multi-cycle ALU for the ARMv4 datapath, the next generation of the single-cycle combinational ALU. Single-cycle operations complete in one clock. Multiply, divide and a new remainder operation run iteratively over M cycles instead of as wide combinational arrays. Operands are latched under a start/busy/done handshake. Results and Z/N/V/C flags are registered and held until the next completion.

## Interface
- M, default 32: operand/result width in bits (≥4, power of two).
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  M  operand A (latched on accepted start).
- b  input  M  operand B / shift amount (latched on accepted start).
- ALUControl  input  4  opcode: 0 ADD, 1 SUB, 2 MULT, 3 DIV, 4 SLL, 5 SRL, 6 AND, 7 OR, 8 XOR, 9 NOT(a), 10 MOD, 11 SRA; 12–15 reserved.
- resultado  output  M  registered result.
- Z, N, V, C  output  1 each  registered flags.
- busy  output  1  high while an iterative op is running.
- done  output  1  one-cycle pulse when resultado/flags update.

## Operation
- FSM states: IDLE, RUN.
- Accept rule: start=1 in IDLE at an edge. Opcode and operands are captured; later changes on a/b/ALUControl are ignored. start in RUN is ignored and not queued.
- Single-cycle ops (0,1,4–9,11, reserved): the result is registered at the accept edge; done=1; state stays IDLE.
- Iterative ops (2,3,10): enter RUN, busy=1, counter=M. Each RUN edge performs one step. On the M-th RUN edge the result and flags are registered, done=1, busy=0, and the state returns to IDLE.
- MULT: unsigned shift-add; resultado = low M bits of a*b.
- DIV/MOD: unsigned restoring division; DIV gives the quotient, MOD the remainder.
- Divide by zero: the op still takes M cycles. DIV gives all-ones; MOD gives a; V=1.
- Shifts: shamt = b as unsigned.
  - shamt ≥ M: SLL/SRL give 0; SRA gives all copies of a[M-1].
  - shamt = 0: result is a.
- Reserved opcodes: result 0, V=1.
- Z = (resultado==0). N = resultado[M-1].
- C:
  - ADD: carry out.
  - SUB: NOT borrow (a ≥ b unsigned).
  - Shifts: last bit shifted out when 1 ≤ shamt ≤ M, else 0.
  - All other ops: 0.
- V:
  - ADD/SUB: signed overflow.
  - MULT: upper M bits of the product nonzero.
  - DIV/MOD: divisor zero.
  - Reserved opcodes: 1.
  - All other ops: 0.
- resultado and flags hold their values between completions.

## Timing
- Reset (asynchronous, active-low): resultado=0, Z=N=V=C=0, busy=0, done=0, state IDLE, counter=0.
- Reset mid-RUN aborts the operation. No done pulse; outputs are zeroed.
- Latency, accept at edge k:
  - Single-cycle ops: done high after edge k, for one cycle.
  - Iterative ops: busy high from after edge k through edge k+M−1; done high after edge k+M.
- Back-to-back: a start sampled at edge k+M (last RUN edge) is ignored. The earliest next accept is edge k+M+1. Single-cycle ops may be accepted on consecutive edges, with done staying high on each.
- done is never asserted in the same cycle as busy.

## Configuration
- ALU_DIV_EN defined: the iterative divider is built; DIV and MOD behave as above.
- ALU_DIV_EN undefined: no divider hardware. Opcodes 3 and 10 complete as single-cycle ops with resultado=0, Z=1, V=1, C=0. MULT is unaffected.

## Test plan
- M=8, ADD a=0x7F b=0x01 → resultado=0x80, N=1, V=1, C=0, Z=0; done one cycle after accept; busy never high.
- M=8, MULT a=0x10 b=0x11 → resultado=0x10, V=1; busy high 8 cycles; done exactly 8 edges after accept. During RUN, toggle a to 0xFF and pulse start: result unchanged, no second done.
- M=8, DIV 200/7 → 0x1C; MOD 200/7 → 0x04; DIV 5/0 → 0xFF, V=1; MOD 5/0 → 0x05, V=1; each takes 8 cycles.
- M=8, shifts: SLL 0x81 by 1 → 0x02, C=1; SRA 0x80 by 9 → 0xFF, C=0; SRL 0x01 by 1 → 0x00, Z=1, C=1.
- Assert reset 3 cycles into a DIV → all outputs 0, no done. After release, ADD 2+3 → 0x05 with done one cycle later.
- Build without ALU_DIV_EN: DIV 200/7 → resultado=0x00, Z=1, V=1; done one cycle after accept; busy never high.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle ALU for the ARMv4 datapath.
// Single-cycle ops (ADD, SUB, shifts, logic) register their result at the
// accept edge. MULT (shift-add) and, when ALU_DIV_EN is defined, DIV/MOD
// (restoring division) iterate for M cycles. Without ALU_DIV_EN, DIV/MOD
// complete in one cycle with resultado=0 and V=1.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       request, sampled only while idle
//   a, b        operands (b is also the shift amount), latched on accept
//   ALUControl  4-bit opcode
//   resultado   registered result
//   Z, N, V, C  registered flags
//   busy        high while an iterative op runs
//   done        one-cycle pulse when resultado/flags update
module alu_multicycle #(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic [3:0]   ALUControl,
  output logic [M-1:0] resultado,
  output logic         Z,
  output logic         N,
  output logic         V,
  output logic         C,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MULT = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_MOD  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam int         CW      = $clog2(M) + 1;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;

  logic [3:0]    op_q;
  logic [M-1:0]  opb_q;          // multiplicand (MULT) or divisor (DIV/MOD)
  logic [M-1:0]  hi_q, lo_q;     // product {hi,lo} or {remainder, quotient}
  logic [CW-1:0] cnt_q;

  logic accept, is_iter, last;

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt_q == CW'(1));

  always_comb begin
    is_iter = (ALUControl == OP_MULT);
`ifdef ALU_DIV_EN
    if (ALUControl == OP_DIV || ALUControl == OP_MOD) is_iter = 1'b1;
`endif
  end

  // ---------------- single-cycle datapath ----------------
  logic [M-1:0] sc_res;
  logic         sc_v, sc_c;
  logic [M:0]   add_w, sll_w, srl_w;
  logic [M-1:0] sub_w;

  always_comb begin
    add_w  = {1'b0, a} + {1'b0, b};
    sub_w  = a - b;
    // Widened shifts keep the last bit shifted out at bit M (left) or bit 0
    // (right); amounts beyond M shift it out too, leaving C=0.
    sll_w  = {1'b0, a} << b;
    srl_w  = {a, 1'b0} >> b;
    sc_res = '0;
    sc_v   = 1'b0;
    sc_c   = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        sc_res = add_w[M-1:0];
        sc_c   = add_w[M];
        sc_v   = (a[M-1] == b[M-1]) && (add_w[M-1] != a[M-1]);
      end
      OP_SUB: begin
        sc_res = sub_w;
        sc_c   = (a >= b);
        sc_v   = (a[M-1] != b[M-1]) && (sub_w[M-1] != a[M-1]);
      end
      OP_SLL: begin sc_res = sll_w[M-1:0]; sc_c = sll_w[M]; end
      OP_SRL: begin sc_res = srl_w[M:1];   sc_c = srl_w[0]; end
      OP_SRA: begin sc_res = $signed(a) >>> b; sc_c = srl_w[0]; end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_XOR: sc_res = a ^ b;
      OP_NOT: sc_res = ~a;
      // Reserved opcodes, plus DIV/MOD when the divider is not built.
      default: sc_v = 1'b1;
    endcase
  end

  // ---------------- iterative datapath ----------------
  logic [M:0]   mul_sum;
  logic [M-1:0] hi_n, lo_n, it_res;
  logic         it_v;

  always_comb begin
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opb_q : {M{1'b0}})};
    hi_n    = mul_sum[M:1];
    lo_n    = {mul_sum[0], lo_q[M-1:1]};
    it_res  = lo_n;
    it_v    = |hi_n;
`ifdef ALU_DIV_EN
    if (op_q != OP_MULT) begin : div_step
      logic [M:0] rsh;
      rsh = {hi_q, lo_q[M-1]};
      if (rsh >= {1'b0, opb_q}) begin
        hi_n = rsh[M-1:0] - opb_q;
        lo_n = {lo_q[M-2:0], 1'b1};
      end else begin
        hi_n = rsh[M-1:0];
        lo_n = {lo_q[M-2:0], 1'b0};
      end
      // Dividing by zero subtracts nothing each step, so the quotient fills
      // with ones and the remainder ends as the dividend.
      it_res = (op_q == OP_MOD) ? hi_n : lo_n;
      it_v   = (opb_q == '0);
    end
`endif
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_iter) state_next = RUN;
      RUN:  if (last)              state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      resultado <= '0;
      Z         <= 1'b0;
      N         <= 1'b0;
      V         <= 1'b0;
      C         <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (is_iter) begin
          op_q  <= ALUControl;
          cnt_q <= CW'(M);
          hi_q  <= '0;
          if (ALUControl == OP_MULT) begin
            lo_q  <= b;
            opb_q <= a;
          end else begin
            lo_q  <= a;
            opb_q <= b;
          end
        end else begin
          resultado <= sc_res;
          Z         <= (sc_res == '0);
          N         <= sc_res[M-1];
          V         <= sc_v;
          C         <= sc_c;
          done      <= 1'b1;
        end
      end else if (state == RUN) begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q - CW'(1);
        if (last) begin
          resultado <= it_res;
          Z         <= (it_res == '0);
          N         <= it_res[M-1];
          V         <= it_v;
          C         <= 1'b0;
          done      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at M=8.
module tb_alu_multicycle;
  localparam int M = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [M-1:0] a = '0;
  logic [M-1:0] b = '0;
  logic [3:0]   ALUControl = '0;
  logic [M-1:0] resultado;
  logic         Z, N, V, C, busy, done;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.M(M)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .ALUControl(ALUControl), .resultado(resultado),
    .Z(Z), .N(N), .V(V), .C(C), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {op, a, b, expected result, expected ZNVC}
  logic [31:0] vec [21] = '{
    32'h0_FF_01_00_9, 32'h0_80_80_00_B, 32'h1_05_03_02_1, 32'h1_03_05_FE_4,
    32'h1_80_01_7F_3, 32'h6_F0_3C_30_0, 32'h7_F0_0F_FF_4, 32'h8_AA_AA_00_8,
    32'h9_0F_00_F0_4, 32'hC_12_34_00_A, 32'hF_FF_FF_00_A, 32'h4_81_01_02_1,
    32'hB_80_09_FF_4, 32'h5_01_01_00_9, 32'h4_5A_00_5A_0, 32'h5_80_08_00_9,
    32'h4_03_08_00_9, 32'hB_40_03_08_0, 32'hB_84_03_F0_5, 32'h5_80_00_80_4,
    32'h4_FF_C8_00_8
  };

  // Presents one request and returns 1 time unit after its accept edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] xa, input logic [7:0] xb);
    @(negedge clk);
    ALUControl = op; a = xa; b = xb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges until done (0 on timeout); busy_ok clears if busy is low
  // before done or high together with done.
  task automatic wait_done(input int limit, output int lat, output bit busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= limit; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({resultado, Z, N, V, C, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: got res=%h ZNVC=%b busy=%b done=%b, want all zero",
               resultado, {Z, N, V, C}, busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_add();
    issue(4'd0, 8'h7F, 8'h01);
    checks++;
    if ({resultado, Z, N, V, C, busy, done} !== {8'h80, 4'b0110, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add_overflow: got res=%h ZNVC=%b busy=%b done=%b, want 80 0110 0 1",
               resultado, {Z, N, V, C}, busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if ({resultado, busy, done} !== {8'h80, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_hold: got res=%h busy=%b done=%b, want 80 0 0", resultado, busy, done);
    end
  endtask

  // Vectors are accepted on consecutive edges, so done must stay high.
  task automatic test_single_cycle();
    logic [31:0] v;
    for (int i = 0; i < 21; i++) begin
      v = vec[i];
      issue(v[31:28], v[27:20], v[19:12]);
      checks++;
      if ({resultado, Z, N, V, C, busy, done} !== {v[11:0], 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL single_%0d op=%h a=%h b=%h: got res=%h ZNVC=%b busy=%b done=%b, want %h %b 0 1",
                 i, v[31:28], v[27:20], v[19:12], resultado, {Z, N, V, C}, busy, done,
                 v[11:4], v[3:0]);
      end
    end
  endtask

  task automatic test_mult();
    int  lat;
    bit  busy_ok;
    bit  extra;
    issue(4'd2, 8'h10, 8'h11);
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL mult_start: got busy=%b done=%b, want 1 0", busy, done);
    end
    lat = 0;
    busy_ok = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 2) begin a = 8'hFF; ALUControl = 4'd0; start = 1'b1; end
      if (n == 3) start = 1'b0;
      if (done) begin lat = n; if (busy) busy_ok = 1'b0; break; end
      if (!busy) busy_ok = 1'b0;
    end
    checks++;
    if (lat != 8 || !busy_ok) begin
      errors++;
      $display("FAIL mult_latency: got %0d edges busy_ok=%b, want 8 edges busy_ok=1", lat, busy_ok);
    end
    checks++;
    if ({resultado, Z, N, V, C} !== {8'h10, 4'b0010}) begin
      errors++;
      $display("FAIL mult_result: got res=%h ZNVC=%b, want 10 0010", resultado, {Z, N, V, C});
    end
    extra = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0 || resultado !== 8'h10) begin
      errors++;
      $display("FAIL mult_no_requeue: got extra=%b res=%h, want 0 10", extra, resultado);
    end
  endtask

  task automatic test_back_to_back();
    issue(4'd2, 8'h03, 8'h05);
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk); #1;
    end
    ALUControl = 4'd0; a = 8'h01; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({resultado, Z, N, V, C, busy, done} !== {8'h0F, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_last_run: got res=%h ZNVC=%b busy=%b done=%b, want 0f 0000 0 1",
               resultado, {Z, N, V, C}, busy, done);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({resultado, Z, N, V, C, busy, done} !== {8'h02, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_next_accept: got res=%h ZNVC=%b busy=%b done=%b, want 02 0000 0 1",
               resultado, {Z, N, V, C}, busy, done);
    end
  endtask

  task automatic test_div();
    int lat;
    bit busy_ok;
    // {op, a, b, result, ZNVC}
    logic [31:0] dv [4] = '{32'h3_C8_07_1C_0, 32'hA_C8_07_04_0,
                            32'h3_05_00_FF_6, 32'hA_05_00_05_2};
`ifdef ALU_DIV_EN
    for (int i = 0; i < 4; i++) begin
      issue(dv[i][31:28], dv[i][27:20], dv[i][19:12]);
      wait_done(20, lat, busy_ok);
      checks++;
      if (lat != 8 || !busy_ok || {resultado, Z, N, V, C} !== dv[i][11:0]) begin
        errors++;
        $display("FAIL div_%0d: got lat=%0d busy_ok=%b res=%h ZNVC=%b, want lat=8 busy_ok=1 %h %b",
                 i, lat, busy_ok, resultado, {Z, N, V, C}, dv[i][11:4], dv[i][3:0]);
      end
    end
`else
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 4; i += 1) begin
      issue(dv[i][31:28], dv[i][27:20], dv[i][19:12]);
      checks++;
      if ({resultado, Z, N, V, C, busy, done} !== {8'h00, 4'b1010, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL nodiv_%0d: got res=%h ZNVC=%b busy=%b done=%b, want 00 1010 0 1",
                 i, resultado, {Z, N, V, C}, busy, done);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00 || lat != 0 || !busy_ok) begin
      errors++;
      $display("FAIL nodiv_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
`endif
  endtask

  task automatic test_reset_mid_run();
    bit extra;
`ifdef ALU_DIV_EN
    issue(4'd3, 8'hC8, 8'h07);
`else
    issue(4'd2, 8'h10, 8'h11);
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy: got busy=%b, want 1", busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({resultado, Z, N, V, C, busy, done} !== '0) begin
      errors++;
      $display("FAIL abort_zero: got res=%h ZNVC=%b busy=%b done=%b, want all zero",
               resultado, {Z, N, V, C}, busy, done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    issue(4'd0, 8'h02, 8'h03);
    checks++;
    if ({resultado, Z, N, V, C, busy, done} !== {8'h05, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL abort_then_add: got res=%h ZNVC=%b busy=%b done=%b, want 05 0000 0 1",
               resultado, {Z, N, V, C}, busy, done);
    end
    extra = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done || busy) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0 || resultado !== 8'h05) begin
      errors++;
      $display("FAIL abort_no_done: got extra=%b res=%h, want 0 05", extra, resultado);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_single_cycle();
    test_mult();
    test_back_to_back();
    test_div();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
